// File: rtl/sumator_pipe.sv
// Pipelined two's-complement adder/subtractor: one BLOCK-bit slice per stage,
// carry registered at every slice boundary, valid/ready flow control.
module sumator_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / BLOCK;
    localparam int unsigned LAST   = STAGES - 1;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("sumator_pipe: WIDTH must be a positive multiple of BLOCK");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  res [STAGES];
    logic [WIDTH-1:0]  opa [STAGES];
    logic [WIDTH-1:0]  opb [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vi;
    logic [STAGES-1:0] ci;
    logic [STAGES-1:0] co;
    logic [WIDTH-1:0]  ai [STAGES];
    logic [WIDTH-1:0]  bi [STAGES];
    logic [WIDTH-1:0]  ri [STAGES];
    logic [WIDTH-1:0]  ro [STAGES];
    logic [BLOCK:0]    sl [STAGES];
    logic [STAGES-1:0] nvld;

    assign nvld = ~vld;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // B is inverted and the sub carry chosen here so sub travels with its op
            assign ai[k] = a;
            assign bi[k] = sub ? ~b : b;
            assign ri[k] = '0;
            assign ci[k] = sub | cin;
            assign vi[k] = in_valid;
        end else begin : g_next
            assign ai[k] = opa[k-1];
            assign bi[k] = opb[k-1];
            assign ri[k] = res[k-1];
            assign ci[k] = carry[k-1];
            assign vi[k] = vld[k-1];
        end

        // A stage may load whenever any stage at or after it has a hole, or the output drains.
        assign adv[k] = out_ready | (|(nvld >> k));

        assign sl[k] = {1'b0, ai[k][k*BLOCK +: BLOCK]}
                     + {1'b0, bi[k][k*BLOCK +: BLOCK]}
                     + {{BLOCK{1'b0}}, ci[k]};
        assign co[k] = sl[k][BLOCK];
        // Slices above k are still zero in the partial result, so OR inserts slice k.
        assign ro[k] = ri[k] | (WIDTH'(sl[k][BLOCK-1:0]) << (k*BLOCK));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld   <= '0;
            carry <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                res[k] <= '0;
                opa[k] <= '0;
                opb[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vi[k];
                    if (vi[k]) begin
                        carry[k] <= co[k];
                        res[k]   <= ro[k];
                        opa[k]   <= ai[k];
                        opb[k]   <= bi[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[LAST];
    assign sum       = res[LAST];
    assign cout      = carry[LAST];
    assign ovf       = (opa[LAST][WIDTH-1] == opb[LAST][WIDTH-1]) &&
                       (res[LAST][WIDTH-1] != opa[LAST][WIDTH-1]);

endmodule

// File: tb/tb_sumator_pipe.sv
// Scoreboard bench for sumator_pipe: directed cases, backpressure, mid-flight
// reset and a randomized stream checked against an arithmetic reference model.
module tb_sumator_pipe;

    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int STAGES = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    sumator_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        exp_t m;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = ux - uy;
            sr = sx - sy;
            m.cout = (ux >= uy);
        end else begin
            r  = ux + uy + int'(c);
            sr = sx + sy + int'(c);
            m.cout = (r > 65535);
        end
        m.sum = r[WIDTH-1:0];
        m.ovf = (sr > 32767) || (sr < -32768);
        m.due = -1;
        return m;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t m;
        m.sum = s; m.cout = c; m.ovf = o; m.due = -1;
        return m;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic ts, input exp_t e, input bit lat);
        int waitc = 0;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitc++;
            if (waitc > 50) break;
            @(posedge clk); #1;
        end
        if (waitc > 50) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            e.due = lat ? cyc + STAGES : -1;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Monitor: compares the DUT output with the scoreboard head whenever it is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    chk("sum",  sum,  e.sum);
                    chk("cout", cout, e.cout);
                    chk("ovf",  ovf,  e.ovf);
                    if (out_ready) begin
                        if (e.due >= 0) chk("latency", cyc, e.due);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] pa [6];
        logic [WIDTH-1:0] pb [6];
        logic             pc [6];
        logic             ps [6];
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        int               acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0), 1'b1);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b1);
        drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b1);
        drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1'b1);
        drain();

        // Back-to-back stream; the latency check also proves consecutive outputs.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), 1'b1);
        end
        drain();

        // Backpressure: six bundles offered against a stalled output.
        for (int i = 0; i < 6; i++) begin
            pa[i] = 16'($urandom); pb[i] = 16'($urandom);
            pc[i] = 1'($urandom);  ps[i] = 1'($urandom);
        end
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = pa[acc]; b = pb[acc]; cin = pc[acc]; sub = ps[acc];
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(pa[acc], pb[acc], pc[acc], ps[acc]));
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 4; i < 6; i++)
            send(pa[i], pb[i], pc[i], ps[i], model(pa[i], pb[i], pc[i], ps[i]), 1'b0);
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            send(ra, rb, 1'b1, 1'b0, model(ra, rb, 1'b1, 1'b0), 1'b0);
        end
        rst_n = 1'b0; in_valid = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_out", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0), 1'b1);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            a = ra; b = rb; cin = rc; sub = rs;
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(model(ra, rb, rc, rs));
            @(posedge clk); #1;
        end
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sumator_pipe.md
Name: sumator_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 16-bit four-block adder.
- Splits the WIDTH-bit operands into BLOCK-bit slices and processes one slice per pipeline stage, so the carry chain is cut at every slice boundary.
- Adds add/sub mode, a signed-overflow flag and valid/ready flow control with backpressure.
- Sits between operand source and ALU result bus; sustains one operation per clock.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of BLOCK (elaboration error otherwise).
- BLOCK, 4, bits per slice, i.e. per pipeline stage.
- STAGES, WIDTH/BLOCK, derived and not overridable; pipeline depth and latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub=1 it is 1 when there is no borrow (a>=b unsigned).
- ovf  output  1  signed overflow: operand signs equal (after B inversion for sub), result sign differs.

Behaviour:
- Transfers: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready.
- Stage k (0..STAGES-1) holds a valid bit, the carry out of slice k, the result slices 0..k and the unprocessed upper operand slices.
- Stage k computes slice k from its operand bits plus the registered carry from stage k-1. Stage 0 uses cin, or 1 when sub=1.
- The inverted-B bits and the sub-derived carry are captured at stage 0, so sub travels with its operation.
- Stage advance rule: stage k loads when stage k+1 is empty or advancing this cycle. The last stage advances on out_ready.
- in_ready = !valid[0] || stage 0 advancing; it is combinational from out_ready through the stall chain.
- Latency: a bundle accepted at edge N gives out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles with no stall.
- Throughput: one operation per cycle when out_ready is held high.
- Stall: with out_ready=0 the output holds sum/cout/ovf stable. Bubbles collapse, so up to STAGES operations are buffered; in_ready falls only when all stages are valid and out_ready=0.
- Simultaneous full and stalled state, then out_ready rising: the output transfer and an input transfer occur in the same cycle with no loss.
- Reset: every stage valid=0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded and no partial result is emitted. Reset overrides any simultaneous transfer.
- Outputs are driven from last-stage registers only, with no combinational path from a/b to sum.
- When out_valid=0, sum/cout/ovf hold their last value (0 after reset).
- Wrap-around: the result is modulo 2^WIDTH. cout and ovf are independent: unsigned and signed overflow are flagged separately.
- STAGES=1 (BLOCK=WIDTH) is legal: a single registered adder with latency 1.

Test Plan:
- Reset, then one add (WIDTH=16, BLOCK=4): a=0x1234, b=0x4321, cin=1, sub=0 -> out_valid after 4 cycles with sum=0x5556, cout=0, ovf=0; all outputs 0 during reset.
- Carry across every slice: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Back-to-back stream: 8 consecutive adds with out_ready=1 -> 8 results in order on 8 consecutive cycles, first at cycle 4.
- Backpressure: hold out_ready=0 while offering 6 bundles -> exactly 4 accepted, in_ready=0 afterwards, sum stable. Release out_ready -> 4 results in order, then the remaining 2, none lost or duplicated.
- Reset mid-flight with 3 operations in the pipe -> no out_valid after reset, in_ready=1. A fresh op issued after reset completes correctly with 4-cycle latency.
